hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
Pipeline sequencing controller for the 5-stage MIPS core; sits beside the forwarding logic in the ID stage. Detects load-use hazards that forwarding cannot resolve and sequences the multi-cycle multiply/divide unit (MDU) busy window. Drives the PC and IF/ID write enables, the IF/ID and ID/EX flushes, and a saturating stall counter.

Parameters:
MDU_LATENCY, 4, EX cycles a mult/div occupies the MDU; legal range 2..15.
STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
clk  input  1  core clock; all state updates on the rising edge
rst  input  1  synchronous active-high reset
ID_EX_MemRead  input  1  instruction in EX is a load
ID_EX_RegisterRt  input  5  destination register of the load in EX
IF_ID_RegisterRs  input  5  rs of the instruction in ID
IF_ID_RegisterRt  input  5  rt of the instruction in ID
IF_ID_UseHiLo  input  1  ID instruction is mfhi/mflo
IF_ID_IsMdu  input  1  ID instruction is mult/multu/div/divu
ID_EX_MduStart  input  1  mult/div is entering EX this cycle
BranchTaken  input  1  branch in ID resolved taken
PCWrite  output  1  PC update enable
IF_ID_Write  output  1  IF/ID register write enable
IF_ID_Flush  output  1  IF/ID register flush (squash fetched instruction)
ID_EX_Flush  output  1  zeroes ID/EX control signals (bubble)
mdu_busy  output  1  MDU occupied
mdu_done  output  1  one-cycle pulse, registered, when MDU result is valid
stall_cnt  output  STALL_CNT_W  count of stall cycles, saturating

Behaviour:
- Reset (rst=1 at edge): state=IDLE, mdu counter=0, mdu_done=0, stall_cnt=0. While rst is high, combinational outputs are forced: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Flush=0, mdu_busy=0. Reset mid-MDU aborts the operation with no mdu_done pulse.
- load_use = ID_EX_MemRead && ID_EX_RegisterRt!=0 && (ID_EX_RegisterRt==IF_ID_RegisterRs || ID_EX_RegisterRt==IF_ID_RegisterRt). Combinational, same cycle.
- FSM states: IDLE, MDU_BUSY.
- IDLE -> MDU_BUSY when ID_EX_MduStart=1; counter loads MDU_LATENCY-1.
- MDU_BUSY: counter decrements each cycle. At counter==0: return to IDLE; mdu_done=1 for exactly the following cycle.
- mdu_busy = (state==MDU_BUSY).
- ID_EX_MduStart while in MDU_BUSY is ignored (no restart, counter unaffected).
- mdu_hazard = mdu_busy && (IF_ID_UseHiLo || IF_ID_IsMdu).
- stall = load_use || mdu_hazard. While stall=1: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
- Branch: BranchTaken && !stall -> IF_ID_Flush=1 for that cycle; PCWrite stays 1.
- Stall has priority over a simultaneous branch: IF_ID_Flush=0, branch is re-evaluated next cycle from the held IF/ID contents.
- Load-use and MDU hazard in the same cycle: single stall; counted once.
- No stall, no branch: PCWrite=1, IF_ID_Write=1, both flushes 0.
- stall_cnt increments by 1 on every edge where stall=1. It holds at 2^STALL_CNT_W-1 and does not wrap.
- All outputs other than mdu_done and stall_cnt are combinational from state and inputs, with zero-cycle latency.

Test Plan:
1. Load-use: ID_EX_MemRead=1, ID_EX_RegisterRt=8, IF_ID_RegisterRs=8 for 1 cycle -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 that cycle; stall_cnt 0->1. Repeat with Rt=0 -> no stall.
2. MDU: ID_EX_MduStart pulse -> mdu_busy=1 for exactly 4 cycles. mdu_done=1 in cycle 5 only. IF_ID_UseHiLo=1 throughout -> 4 stall cycles, stall_cnt=4.
3. Branch vs stall: BranchTaken=1 with load_use=1 -> IF_ID_Flush=0, ID_EX_Flush=1. Next cycle MemRead=0, BranchTaken=1 -> IF_ID_Flush=1, PCWrite=1.
4. Second ID_EX_MduStart during MDU_BUSY (cycle 2) -> ignored; mdu_done still in cycle 5.
5. Reset mid-MDU at cycle 2 -> mdu_busy=0 next cycle, no mdu_done, stall_cnt=0, PCWrite=1.
6. Saturation with STALL_CNT_W=3: hold load_use for 10 cycles -> stall_cnt reaches 7 and stays 7.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// Bundle of the ID-stage hazard signals exchanged between the pipeline
// datapath (master) and the hazard/stall controller (slave).
// All outputs of the controller are valid in the same cycle as its inputs;
// there is no valid/ready handshake, the pipeline simply obeys the enables.
interface hazard_stall_controller_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   ID_EX_MemRead;
    logic [4:0]             ID_EX_RegisterRt;
    logic [4:0]             IF_ID_RegisterRs;
    logic [4:0]             IF_ID_RegisterRt;
    logic                   IF_ID_UseHiLo;
    logic                   IF_ID_IsMdu;
    logic                   ID_EX_MduStart;
    logic                   BranchTaken;
    logic                   PCWrite;
    logic                   IF_ID_Write;
    logic                   IF_ID_Flush;
    logic                   ID_EX_Flush;
    logic                   mdu_busy;
    logic                   mdu_done;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   dbg_state;

    modport master (
        output ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
               IF_ID_UseHiLo, IF_ID_IsMdu, ID_EX_MduStart, BranchTaken,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
               mdu_busy, mdu_done, stall_cnt, dbg_state
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
               IF_ID_UseHiLo, IF_ID_IsMdu, ID_EX_MduStart, BranchTaken,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
               mdu_busy, mdu_done, stall_cnt, dbg_state
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// ID-stage hazard and stall controller for the 5-stage MIPS pipeline.
// Detects load-use hazards, tracks the multi-cycle MDU busy window, and
// drives PC / IF/ID enables, the two flushes and a saturating stall counter.
module hazard_stall_controller #(
    parameter int MDU_LATENCY = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_stall_controller_if.slave bus
);
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] MDU_BUSY = 1'b1;

    // Counter starts at latency-1 so the busy window lasts exactly MDU_LATENCY cycles.
    localparam logic [3:0] LAT_M1 = 4'(MDU_LATENCY - 1);

    logic [0:0]             state_q;
    logic [3:0]             mdu_cnt_q;
    logic                   mdu_done_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic load_use;
    logic mdu_hazard;
    logic stall;
    logic busy;

    // Hazard detection: purely combinational, same-cycle decisions.
    always_comb begin
        busy       = (state_q == MDU_BUSY);
        load_use   = bus.ID_EX_MemRead && (bus.ID_EX_RegisterRt != 5'd0) &&
                     ((bus.ID_EX_RegisterRt == bus.IF_ID_RegisterRs) ||
                      (bus.ID_EX_RegisterRt == bus.IF_ID_RegisterRt));
        mdu_hazard = busy && (bus.IF_ID_UseHiLo || bus.IF_ID_IsMdu);
        stall      = !rst && (load_use || mdu_hazard);
    end

    // Pipeline control outputs; reset forces a free-running, non-flushing pipe.
    always_comb begin
        bus.PCWrite     = 1'b1;
        bus.IF_ID_Write = 1'b1;
        bus.IF_ID_Flush = 1'b0;
        bus.ID_EX_Flush = 1'b0;
        bus.mdu_busy    = 1'b0;
        if (!rst) begin
            bus.mdu_busy = busy;
            if (stall) begin
                // Stall wins over a branch: IF/ID holds, branch re-evaluates next cycle.
                bus.PCWrite     = 1'b0;
                bus.IF_ID_Write = 1'b0;
                bus.ID_EX_Flush = 1'b1;
            end else if (bus.BranchTaken) begin
                bus.IF_ID_Flush = 1'b1;
            end
        end
    end

    // MDU sequencing FSM; a start while already busy is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mdu_cnt_q  <= 4'd0;
            mdu_done_q <= 1'b0;
        end else begin
            mdu_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.ID_EX_MduStart) begin
                        state_q   <= MDU_BUSY;
                        mdu_cnt_q <= LAT_M1;
                    end
                end
                MDU_BUSY: begin
                    if (mdu_cnt_q == 4'd0) begin
                        state_q    <= IDLE;
                        mdu_done_q <= 1'b1;
                    end else begin
                        mdu_cnt_q <= mdu_cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.mdu_done  = mdu_done_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model. Two instances share stimulus: default width and a
// 3-bit stall counter that exercises saturation.
module tb_hazard_stall_controller;
    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_read = 0, hilo = 0, is_mdu = 0, start = 0, br = 0;
    logic [4:0] ex_rt = 0, id_rs = 0, id_rt = 0;

    int n_cmp = 0;
    int n_err = 0;

    hazard_stall_controller_if #(.STALL_CNT_W(16)) bus_a ();
    hazard_stall_controller_if #(.STALL_CNT_W(3))  bus_s ();

    assign bus_a.ID_EX_MemRead = mem_read;    assign bus_s.ID_EX_MemRead = mem_read;
    assign bus_a.ID_EX_RegisterRt = ex_rt;    assign bus_s.ID_EX_RegisterRt = ex_rt;
    assign bus_a.IF_ID_RegisterRs = id_rs;    assign bus_s.IF_ID_RegisterRs = id_rs;
    assign bus_a.IF_ID_RegisterRt = id_rt;    assign bus_s.IF_ID_RegisterRt = id_rt;
    assign bus_a.IF_ID_UseHiLo = hilo;        assign bus_s.IF_ID_UseHiLo = hilo;
    assign bus_a.IF_ID_IsMdu = is_mdu;        assign bus_s.IF_ID_IsMdu = is_mdu;
    assign bus_a.ID_EX_MduStart = start;      assign bus_s.ID_EX_MduStart = start;
    assign bus_a.BranchTaken = br;            assign bus_s.BranchTaken = br;

    hazard_stall_controller #(.MDU_LATENCY(LAT), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );
    hazard_stall_controller #(.MDU_LATENCY(LAT), .STALL_CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus_s.slave)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: cycles of MDU occupancy left, pending done pulse,
    // and an unbounded stall count clipped per instance width.
    int     m_left = 0;
    logic   m_done = 0;
    longint m_cnt  = 0;

    initial begin
        @(posedge clk);
        forever begin
            logic lu, busy, hz, stl;
            @(negedge clk);
            lu   = mem_read && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
            busy = !rst && m_left > 0;
            hz   = busy && (hilo || is_mdu);
            stl  = !rst && (lu || hz);
            chk("m_pcwrite",   bus_a.PCWrite,     !stl);
            chk("m_ifid_wr",   bus_a.IF_ID_Write, !stl);
            chk("m_idex_fl",   bus_a.ID_EX_Flush, stl);
            chk("m_ifid_fl",   bus_a.IF_ID_Flush, !rst && br && !stl);
            chk("m_busy",      bus_a.mdu_busy,    busy);
            chk("m_done",      bus_a.mdu_done,    m_done);
            chk("m_cnt16",     bus_a.stall_cnt,   (m_cnt > 65535) ? 65535 : m_cnt);
            chk("m_cnt3",      bus_s.stall_cnt,   (m_cnt > 7) ? 7 : m_cnt);
            chk("m_sat_pcwr",  bus_s.PCWrite,     !stl);
            // Advance the model to the state after the coming rising edge.
            if (rst) begin
                m_left = 0; m_done = 0; m_cnt = 0;
            end else begin
                if (stl) m_cnt++;
                m_done = (m_left == 1);
                if (m_left > 0) m_left--;
                else if (start) m_left = LAT;
            end
        end
    end

    task automatic cyc(input logic r, input logic ml, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input logic hl,
                       input logic im, input logic st, input logic b);
        @(posedge clk);
        #1;
        rst = r; mem_read = ml; ex_rt = ert; id_rs = rs; id_rt = rt;
        hilo = hl; is_mdu = im; start = st; br = b;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        do_reset();
        do_reset();
        chk("reset_cnt", bus_a.stall_cnt, 0);
        chk("reset_busy", bus_a.mdu_busy, 0);
        chk("reset_pcwr", bus_a.PCWrite, 1);

        // Load-use on rs, then load of $0 which never stalls.
        cyc(0, 1, 8, 8, 3, 0, 0, 0, 0);
        chk("lu_pcwr", bus_a.PCWrite, 0);
        chk("lu_ifid_wr", bus_a.IF_ID_Write, 0);
        chk("lu_idex_fl", bus_a.ID_EX_Flush, 1);
        idle();
        chk("lu_cnt1", bus_a.stall_cnt, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_pcwr", bus_a.PCWrite, 1);
        chk("r0_idex_fl", bus_a.ID_EX_Flush, 0);
        idle();
        chk("r0_cnt1", bus_a.stall_cnt, 1);

        // MDU window with mfhi waiting in ID throughout.
        do_reset();
        cyc(0, 0, 0, 0, 0, 1, 0, 1, 0);
        chk("mdu_c0_busy", bus_a.mdu_busy, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
            chk("mdu_busy", bus_a.mdu_busy, 1);
            chk("mdu_stall", bus_a.PCWrite, 0);
            chk("mdu_nodone", bus_a.mdu_done, 0);
        end
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("mdu_c5_busy", bus_a.mdu_busy, 0);
        chk("mdu_c5_done", bus_a.mdu_done, 1);
        chk("mdu_c5_cnt", bus_a.stall_cnt, 4);
        idle();
        chk("mdu_c6_done", bus_a.mdu_done, 0);

        // Second start in cycle 2 is ignored.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        chk("restart_c1", bus_a.mdu_busy, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        idle();
        chk("restart_c4", bus_a.mdu_busy, 1);
        idle();
        chk("restart_c5_done", bus_a.mdu_done, 1);
        chk("restart_c5_busy", bus_a.mdu_busy, 0);
        idle();
        chk("restart_c6_busy", bus_a.mdu_busy, 0);

        // Stall beats a taken branch; branch goes through next cycle.
        cyc(0, 1, 5, 1, 5, 0, 0, 0, 1);
        chk("brst_ifid_fl", bus_a.IF_ID_Flush, 0);
        chk("brst_idex_fl", bus_a.ID_EX_Flush, 1);
        cyc(0, 0, 5, 1, 5, 0, 0, 0, 1);
        chk("br_ifid_fl", bus_a.IF_ID_Flush, 1);
        chk("br_pcwr", bus_a.PCWrite, 1);

        // Reset in the middle of an MDU operation.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 7, 7, 0, 1, 0, 0, 0);
        cyc(1, 1, 7, 7, 0, 1, 0, 0, 0);
        chk("rstmid_pcwr", bus_a.PCWrite, 1);
        chk("rstmid_busy", bus_a.mdu_busy, 0);
        idle();
        chk("rstmid_after_busy", bus_a.mdu_busy, 0);
        chk("rstmid_after_done", bus_a.mdu_done, 0);
        chk("rstmid_after_cnt", bus_a.stall_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("rstmid_no_done", bus_a.mdu_done, 0);
        end

        // Saturation of the narrow counter.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(0, 1, 9, 2, 9, 0, 0, 0, 0);
        idle();
        chk("sat_cnt3", bus_s.stall_cnt, 7);
        chk("sat_cnt16", bus_a.stall_cnt, 10);
        idle();
        chk("sat_hold", bus_s.stall_cnt, 7);

        // Randomized traffic; small register range to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 2) == 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
